// File: rtl/quad_hbridge_pwm_driver_pkg.sv
// Shared motor command codes, channel state encoding and default sizing for the quad H-bridge driver.
// Combinational helpers only; no latency, no backpressure.
package quad_hbridge_pwm_driver_pkg;

  localparam int NUM_MOTORS      = 4;
  localparam int CNT_W_DEF       = 8;
  localparam int DEAD_CYCLES_DEF = 4;

  localparam logic [1:0] SEL_COAST = 2'b00;
  localparam logic [1:0] SEL_FWD   = 2'b01;
  localparam logic [1:0] SEL_REV   = 2'b10;
  localparam logic [1:0] SEL_BRAKE = 2'b11;

  typedef enum logic [2:0] {
    CH_OFF  = 3'd0,
    CH_DEAD = 3'd1,
    CH_FWD  = 3'd2,
    CH_REV  = 3'd3,
    CH_BRK  = 3'd4
  } ch_state_t;

  function automatic ch_state_t sel_to_state(input logic [1:0] sel);
    case (sel)
      SEL_FWD:   return CH_FWD;
      SEL_REV:   return CH_REV;
      SEL_BRAKE: return CH_BRK;
      default:   return CH_OFF;
    endcase
  endfunction

endpackage

// File: rtl/quad_hbridge_pwm_driver_if.sv
// Command/duty inputs and gate outputs of the quad H-bridge driver.
// Pure wiring; no latency, no backpressure.
interface quad_hbridge_pwm_driver_if #(
  parameter int CNT_W = quad_hbridge_pwm_driver_pkg::CNT_W_DEF
);
  localparam int NM = quad_hbridge_pwm_driver_pkg::NUM_MOTORS;

  logic [2*NM-1:0]     sel_protected;
  logic [NM*CNT_W-1:0] duty;
  logic                duty_load;
  logic [NM-1:0]       in1;
  logic [NM-1:0]       in2;
  logic                period_start;

  modport master (
    output sel_protected, duty, duty_load,
    input  in1, in2, period_start
  );

  modport slave (
    input  sel_protected, duty, duty_load,
    output in1, in2, period_start
  );

endinterface

// File: rtl/quad_hbridge_pwm_driver_channel.sv
// One H-bridge channel: mode FSM with dead-time between opposing drive modes, registered gates.
// Gates follow sel two edges after it is sampled (+DEAD_CYCLES when dead time applies); no backpressure.
module hbridge_pwm_channel
  import quad_hbridge_pwm_driver_pkg::*;
#(
  parameter int DEAD_CYCLES = DEAD_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sel,
  input  logic       pwm,
  output logic       in1,
  output logic       in2
);

  localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [DW-1:0] DEAD_INIT = DW'(DEAD_CYCLES - 1);

  logic [1:0]    sel_q;
  logic [1:0]    target, target_nxt;
  logic [DW-1:0] dead_cnt, dead_nxt;
  ch_state_t     state, state_nxt;
  logic          in1_nxt, in2_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q    <= SEL_COAST;
      state    <= CH_OFF;
      target   <= SEL_COAST;
      dead_cnt <= '0;
      in1      <= 1'b0;
      in2      <= 1'b0;
    end else begin
      sel_q    <= sel;
      state    <= state_nxt;
      target   <= target_nxt;
      dead_cnt <= dead_nxt;
      in1      <= in1_nxt;
      in2      <= in2_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    target_nxt = target;
    dead_nxt   = dead_cnt;
    case (state)
      CH_OFF: state_nxt = sel_to_state(sel_q);
      CH_FWD, CH_REV, CH_BRK: begin
        if (sel_q == SEL_COAST) begin
          state_nxt = CH_OFF;
        end else if (sel_to_state(sel_q) != state) begin
          state_nxt  = CH_DEAD;
          target_nxt = sel_q;
          dead_nxt   = DEAD_INIT;
        end
      end
      CH_DEAD: begin
        // A retarget while dead keeps the running count so the gap is never stretched or cut.
        if (sel_q == SEL_COAST) begin
          state_nxt = CH_OFF;
        end else begin
          target_nxt = sel_q;
          if (dead_cnt == '0) state_nxt = sel_to_state(target_nxt);
          else                dead_nxt  = dead_cnt - 1'b1;
        end
      end
      default: state_nxt = CH_OFF;
    endcase
  end

  always_comb begin
    in1_nxt = 1'b0;
    in2_nxt = 1'b0;
    case (state_nxt)
      CH_FWD:  in1_nxt = pwm;
      CH_REV:  in2_nxt = pwm;
      CH_BRK: begin
        in1_nxt = 1'b1;
        in2_nxt = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/quad_hbridge_pwm_driver.sv
// Quad H-bridge gate driver: shared PWM counter, shadowed per-motor duty, four dead-time channels.
// Gates registered (sel to gate two edges, duty applies at next wrap); no backpressure.
module quad_hbridge_pwm_driver
  import quad_hbridge_pwm_driver_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEAD_CYCLES = DEAD_CYCLES_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  quad_hbridge_pwm_driver_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(2**CNT_W - 2);

  logic [CNT_W-1:0]      cnt;
  logic                  period_start;
  logic [CNT_W-1:0]      pending [NUM_MOTORS];
  logic [CNT_W-1:0]      active  [NUM_MOTORS];
  logic [NUM_MOTORS-1:0] pwm;
  logic [NUM_MOTORS-1:0] in1_w, in2_w;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      period_start <= 1'b0;
      for (int m = 0; m < NUM_MOTORS; m++) begin
        pending[m] <= '0;
        active[m]  <= '0;
      end
    end else begin
      cnt          <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
      period_start <= (cnt == '0);
      // A load on the wrap edge lands in pending only; active picks up the previous pending.
      for (int m = 0; m < NUM_MOTORS; m++) begin
        if (bus.duty_load)   pending[m] <= bus.duty[m*CNT_W +: CNT_W];
        if (cnt == CNT_MAX)  active[m]  <= pending[m];
      end
    end
  end

  for (genvar g = 0; g < NUM_MOTORS; g++) begin : g_ch
    assign pwm[g] = (cnt < active[g]);

    hbridge_pwm_channel #(
      .DEAD_CYCLES (DEAD_CYCLES)
    ) u_ch (
      .clk (clk),
      .rst (rst),
      .sel (bus.sel_protected[2*g +: 2]),
      .pwm (pwm[g]),
      .in1 (in1_w[g]),
      .in2 (in2_w[g])
    );
  end

  assign bus.in1          = in1_w;
  assign bus.in2          = in2_w;
  assign bus.period_start = period_start;

endmodule
